// File: rtl/piso_tx_if.sv
// piso_tx_if: handshake and serial-stream bundle for piso_tx.
//   din/din_valid/din_ready : parallel word handshake (source -> transmitter)
//   serial_out/bit_valid    : serial bit stream, MSB first
//   word_done               : pulse on the final bit of a word
//   busy                    : a word is in flight
// Modports: master = word source / stream sink, slave = the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, serial_out, bit_valid, word_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, serial_out, bit_valid, word_done, busy
  );
endinterface

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out MSB first, one bit per clock, so a
// downstream shift-left register reassembles the word in original order.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : piso_tx_if.slave (din, din_valid, din_ready, serial_out,
//           bit_valid, word_done, busy)
// Option macro: PISO_TX_PARITY_EN appends an even-parity bit after the data
// bits (extra PARITY cycle). Undefined by default.
// All outputs decode from registered state/shreg/bit_cnt/par only; nothing
// depends combinationally on din or din_valid.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  piso_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             last_data;
  logic             final_bit;
  logic             accept;

  assign last_data = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));

`ifdef PISO_TX_PARITY_EN
  logic par;  // running XOR of the bits already sent
  assign final_bit = (state == PARITY);
`else
  assign final_bit = last_data;
`endif

  // Ready from state only, so the source sees a stable ready all cycle.
  assign bus.din_ready = (state == IDLE) || final_bit;
  assign accept        = bus.din_valid && bus.din_ready;

  always_comb begin
    bus.serial_out = 1'b0;
    bus.bit_valid  = 1'b0;
    case (state)
      SHIFT: begin
        bus.serial_out = shreg[WIDTH-1];
        bus.bit_valid  = 1'b1;
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        bus.serial_out = par;
        bus.bit_valid  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.word_done = final_bit;
  assign bus.busy      = bus.bit_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CW'(1);
`ifdef PISO_TX_PARITY_EN
          par     <= par ^ shreg[WIDTH-1];
          if (last_data) state <= PARITY;
`else
          if (last_data) state <= IDLE;
`endif
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: state <= IDLE;
`endif
        default: ;
      endcase
      // A transfer (IDLE or final-bit cycle) overrides the updates above and
      // starts the new word's MSB next cycle with no gap.
      if (accept) begin
        state   <= SHIFT;
        shreg   <= bus.din;
        bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
        par     <= 1'b0;
`endif
      end
    end
  end
endmodule
